game_ctrl: RTL and testbench
============================

# game_ctrl

Game sequencer between the VGA timing generator and the pattern generator, running on the PLL pixel clock. It synchronises and debounces the raw `start` and `donato` pushbuttons and derives a once-per-frame tick from the row/column counters. It runs the IDLE / COUNTDOWN / PLAY / OVER state machine and keeps the current and high score. The pattern generator consumes its registered outputs instead of raw buttons.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles needed before a debounced button changes (about 10 ms at the pixel clock).
- `FRAME_ROW`, 480: row value at which the frame tick fires (first blanking line).
- `COUNTDOWN_FRAMES`, 180: frames spent in COUNTDOWN (3 s at 60 Hz).
- `OVER_FRAMES`, 120: minimum frames spent in OVER before `start` is honoured.
- `MAX_SCORE`, 99: saturation value of `score`; must be at most 127.
- `CLK` in 1: pixel clock, the only clock.
- `reset` in 1: synchronous, active-high.
- `Row` in 10: current VGA row.
- `Col` in 10: current VGA column.
- `start` in 1: raw start button, asynchronous, active-high.
- `donato` in 1: raw action button, asynchronous, active-high.
- `point` in 1: one-cycle pulse from the datapath that scores one point.
- `hit` in 1: one-cycle pulse from the datapath that ends the game.
- `state` out 2: 0 = IDLE, 1 = COUNTDOWN, 2 = PLAY, 3 = OVER.
- `frame_tick` out 1: one-cycle pulse per frame.
- `action_pulse` out 1: one-cycle pulse on each debounced `donato` press while in PLAY.
- `frames_left` out 8: remaining COUNTDOWN frames; 0 outside COUNTDOWN.
- `score` out 7: current score.
- `high_score` out 7: best score since reset.

## Operation
**Button path**
- `start` and `donato` each pass through a 2-flop synchroniser.
- Each synchronised button has its own debounce counter:
  - The counter resets whenever the synchronised value equals the debounced value.
  - The debounced value flips when the counter reaches `DEBOUNCE_CYCLES - 1` with the input still differing.
- A rising-edge detector on each debounced value produces `start_p` and `act_p`, each one cycle wide.

**Frame tick**
- `frame_tick` = registered (`Row == FRAME_ROW` && `Col == 0`).

**State machine**
- IDLE:
  - `start_p` → COUNTDOWN. On the same edge: `score` ← 0, frame counter ← `COUNTDOWN_FRAMES`.
- COUNTDOWN:
  - Each `frame_tick` decrements the counter.
  - A tick that arrives with the counter at 1 → PLAY, counter ← 0.
  - `start_p` is ignored.
- PLAY:
  - `point` → `score` + 1, saturating at `MAX_SCORE`.
  - `hit` → OVER, frame counter ← `OVER_FRAMES`.
  - If `point` and `hit` arrive in the same cycle, the point is counted first, then the state goes to OVER.
  - `action_pulse` = `act_p`.
  - `start_p` is ignored.
- OVER:
  - Each `frame_tick` decrements the counter until it reaches 0.
  - `start_p` with counter == 0 → COUNTDOWN, with the same loads as from IDLE.
  - `start_p` with counter != 0 is ignored.
  - `high_score` ← max(`high_score`, final `score`) on the PLAY→OVER edge. The final score includes any simultaneous point.
- `point` and `hit` are ignored outside PLAY.
- `act_p` is suppressed (`action_pulse` = 0) outside PLAY.
- `frames_left` = frame counter in COUNTDOWN, otherwise 0.

**Reset** (valid at any cycle, including mid-game or mid-debounce)
- `state` = IDLE.
- `score`, `high_score`, `frames_left`, `frame_tick`, `action_pulse` = 0.
- Synchronisers, debounced values and debounce counters = 0.
- `high_score` is cleared only by `reset`.

**Arithmetic**
- Frame counter is 8 bits; parameters must be at most 255.
- Debounce counter width = $clog2(`DEBOUNCE_CYCLES`).
- Score compare and saturate are unsigned 7-bit.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- Button press to pulse: 2 synchroniser cycles + `DEBOUNCE_CYCLES` + 1 edge cycle, then the state or `action_pulse` changes on the next edge.
- `frame_tick` is high the cycle after `Row`/`Col` = (`FRAME_ROW`, 0), exactly once per frame.
- `point` and `hit` take effect on the edge where they are sampled; `score` and `state` are visible the next cycle.
- A button held continuously produces exactly one pulse. Bounces shorter than `DEBOUNCE_CYCLES` produce none.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `COUNTDOWN_FRAMES`=3, `OVER_FRAMES`=2, `MAX_SCORE`=5; a fake Row/Col counter drives the frame ticks.
- Reset, then no stimulus → `state`=0, `score`=0, `high_score`=0, exactly one `frame_tick` per fake frame.
- Toggle `start` high/low every 2 cycles for 20 cycles → no state change. Then hold `start` high → `state`=1 and `frames_left`=3 appear 2+4+1+1 cycles after the rise.
- From COUNTDOWN → `frames_left` steps 3, 2, 1 on successive ticks, then `state`=2 with `frames_left`=0. Pressing `start` mid-countdown has no effect.
- In PLAY, send 7 `point` pulses → `score` reaches 5 and holds. Then `point`+`hit` in the same cycle → `state`=3, `score`=5, `high_score`=5.
- In OVER, press `start` before 2 ticks → ignored. Press after 2 ticks → `state`=1, `score`=0, `high_score` stays 5.
- Assert `reset` mid-PLAY while `donato` is bouncing → next cycle all outputs are 0 and `state`=0. No `action_pulse` is produced after reset until a fresh debounced press in PLAY.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: button debounce, frame tick and IDLE/COUNTDOWN/PLAY/OVER sequencer with score keeping
// Ports: CLK/reset (sync, active-high); Row/Col from the VGA timer; start/donato raw buttons;
//        point/hit datapath pulses; state, frame_tick, action_pulse, frames_left, score, high_score
//        are all registered.
module game_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 250000,
    parameter int FRAME_ROW        = 480,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int OVER_FRAMES      = 120,
    parameter int MAX_SCORE        = 99
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [9:0] Row,
    input  logic [9:0] Col,
    input  logic       start,
    input  logic       donato,
    input  logic       point,
    input  logic       hit,
    output logic [1:0] state,
    output logic       frame_tick,
    output logic       action_pulse,
    output logic [7:0] frames_left,
    output logic [6:0] score,
    output logic [6:0] high_score
);
    typedef enum logic [1:0] {IDLE, COUNTDOWN, PLAY, OVER} st_t;
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    st_t st;
    logic [1:0] btn, s1, s2, db, db_d, rise;
    logic [CW-1:0] cnt [2];
    logic [7:0] fc;
    logic [6:0] score_n;
    assign state = st;
    assign btn = {donato, start};
    // score after this cycle's point, so a simultaneous hit records it in high_score
    assign score_n = (point && score < 7'(MAX_SCORE)) ? score + 7'd1 : score;
    always_ff @(posedge CLK) begin
        if (reset) begin
            s1           <= '0;
            s2           <= '0;
            db           <= '0;
            db_d         <= '0;
            rise         <= '0;
            cnt[0]       <= '0;
            cnt[1]       <= '0;
            st           <= IDLE;
            fc           <= '0;
            frames_left  <= '0;
            score        <= '0;
            high_score   <= '0;
            frame_tick   <= 1'b0;
            action_pulse <= 1'b0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            db_d <= db;
            rise <= db & ~db_d;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) cnt[i] <= '0;
                else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i] <= '0;
                    db[i]  <= ~db[i];
                end else cnt[i] <= cnt[i] + CW'(1);
            end
            frame_tick   <= Row == 10'(FRAME_ROW) && Col == 10'd0;
            action_pulse <= st == PLAY && rise[1];
            case (st)
                IDLE: if (rise[0]) begin
                    st          <= COUNTDOWN;
                    score       <= '0;
                    fc          <= 8'(COUNTDOWN_FRAMES);
                    frames_left <= 8'(COUNTDOWN_FRAMES);
                end
                COUNTDOWN: if (frame_tick) begin
                    if (fc == 8'd1) begin
                        st          <= PLAY;
                        fc          <= '0;
                        frames_left <= '0;
                    end else begin
                        fc          <= fc - 8'd1;
                        frames_left <= fc - 8'd1;
                    end
                end
                PLAY: begin
                    score <= score_n;
                    if (hit) begin
                        st <= OVER;
                        fc <= 8'(OVER_FRAMES);
                        if (score_n > high_score) high_score <= score_n;
                    end
                end
                OVER: begin
                    if (rise[0] && fc == 8'd0) begin
                        st          <= COUNTDOWN;
                        score       <= '0;
                        fc          <= 8'(COUNTDOWN_FRAMES);
                        frames_left <= 8'(COUNTDOWN_FRAMES);
                    end else if (frame_tick && fc != 8'd0) fc <= fc - 8'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed stimulus with a per-cycle reference model and literal checkpoints
module tb_game_ctrl;
    localparam int DB = 4, CF = 3, OF = 2, MS = 5, FR = 5, NCOL = 4, NROW = 8;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, donato = 1'b0, point = 1'b0, hit = 1'b0;
    logic [9:0] row = '0, col = '0;
    logic [1:0] state;
    logic frame_tick, action_pulse;
    logic [7:0] frames_left;
    logic [6:0] score, high_score;
    int checks = 0, errors = 0;
    game_ctrl #(
        .DEBOUNCE_CYCLES(DB), .FRAME_ROW(FR), .COUNTDOWN_FRAMES(CF),
        .OVER_FRAMES(OF), .MAX_SCORE(MS)
    ) dut (
        .CLK(clk), .reset(reset), .Row(row), .Col(col), .start(start), .donato(donato),
        .point(point), .hit(hit), .state(state), .frame_tick(frame_tick),
        .action_pulse(action_pulse), .frames_left(frames_left), .score(score),
        .high_score(high_score)
    );
    always #5 clk = ~clk;
    // fake VGA scan: NCOL columns by NROW rows, one frame every 32 cycles
    always @(negedge clk) begin
        if (col == 10'(NCOL - 1)) begin
            col = '0;
            row = (row == 10'(NROW - 1)) ? 10'd0 : row + 10'd1;
        end else col = col + 10'd1;
    end
    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask
    // reference model: raw sample history drives a stable-window debounce, then the game rules
    logic [1:0] h [0:DB+1];
    logic [1:0] m_db, m_dbp, m_rise;
    int m_state, m_score, m_hs, m_fc, m_fl;
    bit m_ft, m_ap, m_sp, m_tk, m_flip, armed = 0;
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= DB + 1; k++) h[k] = '0;
            m_db = '0; m_dbp = '0; m_rise = '0;
            m_state = 0; m_score = 0; m_hs = 0; m_fc = 0; m_fl = 0;
            m_ft = 0; m_ap = 0;
            armed = 1;
        end else begin
            for (int k = DB + 1; k > 0; k--) h[k] = h[k-1];
            h[0] = {donato, start};
            m_sp = m_rise[0];
            m_tk = m_ft;
            m_ap = (m_state == 2) && m_rise[1];
            m_rise = m_db & ~m_dbp;
            m_dbp = m_db;
            for (int b = 0; b < 2; b++) begin
                m_flip = 1;
                for (int k = 2; k <= DB + 1; k++) if (h[k][b] == m_db[b]) m_flip = 0;
                if (m_flip) m_db[b] = ~m_db[b];
            end
            m_ft = (row == 10'(FR)) && (col == 10'd0);
            if (m_state == 0 || (m_state == 3 && m_sp && m_fc == 0)) begin
                if (m_sp) begin
                    m_state = 1; m_score = 0; m_fc = CF;
                end
            end else if (m_state == 1) begin
                if (m_tk) begin
                    m_fc = m_fc - 1;
                    if (m_fc == 0) m_state = 2;
                end
            end else if (m_state == 2) begin
                m_score = (m_score + int'(point) > MS) ? MS : m_score + int'(point);
                if (hit) begin
                    m_state = 3; m_fc = OF;
                    m_hs = (m_score > m_hs) ? m_score : m_hs;
                end
            end else if (m_tk && m_fc > 0) m_fc = m_fc - 1;
            m_fl = (m_state == 1) ? m_fc : 0;
        end
    end
    always @(negedge clk) begin
        if (armed) begin
            chk("state", int'(state), m_state);
            chk("score", int'(score), m_score);
            chk("high_score", int'(high_score), m_hs);
            chk("frames_left", int'(frames_left), m_fl);
            chk("frame_tick", int'(frame_tick), int'(m_ft));
            chk("action_pulse", int'(action_pulse), int'(m_ap));
        end
    end
    int ap_cnt = 0, ft_cnt = 0;
    logic [7:0] fl_last = '0;
    int fl_seen [$];
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ap_cnt += int'(action_pulse);
            ft_cnt += int'(frame_tick);
            if (state == 2'd1 && frames_left != fl_last) fl_seen.push_back(int'(frames_left));
            fl_last = frames_left;
        end
    endtask
    task automatic wait_state(input int s, input int budget, input string nm);
        int n = 0;
        while (int'(state) != s && n < budget) begin
            step(1);
            n++;
        end
        chk(nm, int'(state), s);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        step(3);
        reset = 1'b0;
        chk("reset_state", int'(state), 0);
        chk("reset_score", int'(score), 0);
        chk("reset_high", int'(high_score), 0);
        ft_cnt = 0;
        step(64);
        chk("ticks_per_2_frames", ft_cnt, 2);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; step(2);
            start = 1'b0; step(2);
        end
        step(8);
        chk("bounce_ignored", int'(state), 0);
        fl_seen.delete();
        start = 1'b1;
        step(7);
        chk("start_latency_early", int'(state), 0);
        step(1);
        chk("start_latency_state", int'(state), 1);
        chk("start_latency_frames", int'(frames_left), 3);
        step(10);
        start = 1'b0; step(10);
        start = 1'b1; step(12);
        start = 1'b0;
        chk("countdown_start_ignored", int'(state), 1);
        wait_state(2, 200, "enter_play");
        chk("fl_steps", fl_seen.size(), 3);
        if (fl_seen.size() == 3) begin
            chk("fl_step0", fl_seen[0], 3);
            chk("fl_step1", fl_seen[1], 2);
            chk("fl_step2", fl_seen[2], 1);
        end
        chk("play_frames_left", int'(frames_left), 0);
        for (int i = 1; i <= 7; i++) begin
            point = 1'b1; step(1);
            point = 1'b0;
            chk("point_score", int'(score), i > MS ? MS : i);
            step(1);
        end
        point = 1'b1; hit = 1'b1; step(1);
        point = 1'b0; hit = 1'b0;
        chk("hit_state", int'(state), 3);
        chk("hit_score", int'(score), 5);
        chk("hit_high", int'(high_score), 5);
        start = 1'b1; step(12);
        start = 1'b0; step(10);
        chk("over_early_start", int'(state), 3);
        step(70);
        start = 1'b1;
        wait_state(1, 20, "over_restart");
        chk("restart_score", int'(score), 0);
        chk("restart_high", int'(high_score), 5);
        step(5);
        start = 1'b0;
        wait_state(2, 200, "enter_play2");
        ap_cnt = 0;
        donato = 1'b1; step(15);
        donato = 1'b0; step(10);
        chk("one_action_pulse", ap_cnt, 1);
        donato = 1'b1; step(3);
        donato = 1'b0; step(1);
        donato = 1'b1; step(2);
        reset = 1'b1; step(1);
        chk("rst_state", int'(state), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_high", int'(high_score), 0);
        chk("rst_frames_left", int'(frames_left), 0);
        chk("rst_frame_tick", int'(frame_tick), 0);
        chk("rst_action", int'(action_pulse), 0);
        reset = 1'b0;
        ap_cnt = 0;
        step(20);
        donato = 1'b0; step(10);
        chk("no_action_after_reset", ap_cnt, 0);
        chk("idle_after_reset", int'(state), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
